// File: rtl/latch_loader.sv
// Latch loader: accepts words over valid/ready and drives a latch's D/G inputs
// as a timed set-up / gate-open / hold sequence.
module latch_loader #(
  parameter int unsigned LATCH_WIDTH = 4,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned OPEN_CYC    = 1,
  parameter int unsigned HOLD_CYC    = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [LATCH_WIDTH-1:0] IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [LATCH_WIDTH-1:0] D,
  output logic                   G,
  output logic                   BUSY,
  output logic [7:0]             LOAD_CNT
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LATCH_WIDTH-1:0] data_q, data_d;
  logic                   gate_q, gate_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       load_cnt_q, load_cnt_d;

  // State and output registers; reset drops the gate immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      gate_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      load_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      gate_q     <= gate_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  // Next-state and next-output logic; each phase ends when the counter hits zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    gate_d     = gate_q;
    load_cnt_d = load_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (IN_VALID && ready_q) begin
          data_d  = IN_DATA;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          gate_d  = 1'b1;
          cnt_d   = CNT_W'(OPEN_CYC - 1);
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          gate_d     = 1'b0;
          load_cnt_d = load_cnt_q + CNT_W'(1);
          cnt_d      = CNT_W'(HOLD_CYC - 1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign IN_READY = ready_q;
  assign D        = data_q;
  assign G        = gate_q;
  assign BUSY     = busy_q;
  assign LOAD_CNT = load_cnt_q;

endmodule

// File: tb/tb_latch_loader.sv
// Testbench for latch_loader: a default-timing and a custom-timing instance
// compared every cycle against a timeline model built from accept times.
module tb_latch_loader;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data  [2];
  logic         in_valid [2];
  logic         in_ready [2];
  logic [W-1:0] d_o      [2];
  logic         g_o      [2];
  logic         busy_o   [2];
  logic [7:0]   lc_o     [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Phase lengths per instance, and the model state.
  int           s_cyc [2];
  int           o_cyc [2];
  int           h_cyc [2];
  int           acc_e [2];
  logic [W-1:0] m_d   [2];
  int           m_lc  [2];
  logic         m_rdy [2];
  logic         m_g   [2];
  logic         m_busy[2];
  bit           acc   [2];
  int           cyc = 0;

  always #5 clk = ~clk;

  latch_loader #(.LATCH_WIDTH(W)) u_def (
    .CLK(clk), .RST(rst), .IN_DATA(in_data[0]), .IN_VALID(in_valid[0]),
    .IN_READY(in_ready[0]), .D(d_o[0]), .G(g_o[0]), .BUSY(busy_o[0]),
    .LOAD_CNT(lc_o[0])
  );

  latch_loader #(.LATCH_WIDTH(W), .SETUP_CYC(3), .OPEN_CYC(2), .HOLD_CYC(4)) u_cus (
    .CLK(clk), .RST(rst), .IN_DATA(in_data[1]), .IN_VALID(in_valid[1]),
    .IN_READY(in_ready[1]), .D(d_o[1]), .G(g_o[1]), .BUSY(busy_o[1]),
    .LOAD_CNT(lc_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc_e[i]  = -1;
      m_d[i]    = '0;
      m_lc[i]   = 0;
      m_rdy[i]  = 1'b0;
      m_g[i]    = 1'b0;
      m_busy[i] = 1'b0;
      acc[i]    = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("g%0d", i),     32'(g_o[i]),      32'(m_g[i]));
      check($sformatf("d%0d", i),     32'(d_o[i]),      32'(m_d[i]));
      check($sformatf("ready%0d", i), 32'(in_ready[i]), 32'(m_rdy[i]));
      check($sformatf("busy%0d", i),  32'(busy_o[i]),   32'(m_busy[i]));
      check($sformatf("lcnt%0d", i),  32'(lc_o[i]),     32'(m_lc[i] % 256));
    end
  endtask

  // One clock edge: predict outputs from the accept time, then compare.
  task automatic tick();
    int  k;
    bit  active;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        acc[i] = 1'b0;
        if (m_rdy[i] && in_valid[i]) begin
          acc[i]   = 1'b1;
          acc_e[i] = cyc;
          m_d[i]   = in_data[i];
        end
        k      = (acc_e[i] >= 0) ? cyc - acc_e[i] : 1 << 20;
        active = (k < s_cyc[i] + o_cyc[i] + h_cyc[i]);
        if (k == s_cyc[i] + o_cyc[i]) m_lc[i]++;
        m_g[i]    = active && (k >= s_cyc[i]) && (k < s_cyc[i] + o_cyc[i]);
        m_busy[i] = active;
        m_rdy[i]  = !active;
      end
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nxt;
    int a, rise, glen, rdy_ret, prev_lc;
    bit seen;
    s_cyc = '{1, 3};
    o_cyc = '{1, 2};
    h_cyc = '{1, 4};
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b1;
      in_data[i]  = 4'h3;
    end
    #2;
    check_all();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;

    // First edge after release only raises IN_READY; the second accepts.
    in_data[0] = 4'hA;
    in_valid[1] = 1'b0;
    tick();
    check("ready_first_edge", 32'(in_ready[0]), 32'd1);
    check("no_accept_first", 32'(busy_o[0]), 32'd0);
    tick();
    check("accept_second", 32'(d_o[0]), 32'hA);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("single_lc", 32'(lc_o[0]), 32'd1);

    // Continuous stream 0..15 on the default instance.
    do_reset();
    nxt = 0;
    in_valid[0] = 1'b1;
    in_data[0]  = '0;
    for (int t = 0; t < 200 && nxt < 16; t++) begin
      tick();
      if (acc[0]) begin
        nxt++;
        in_data[0] = W'(nxt);
        if (nxt == 16) in_valid[0] = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) tick();
    check("stream_lc", 32'(lc_o[0]), 32'd16);

    // Custom timing measured directly in cycles from the accept edge.
    in_data[1]  = 4'h5;
    in_valid[1] = 1'b1;
    a = -1; rise = -1; glen = 0; rdy_ret = -1;
    for (int t = 0; t < 40 && rdy_ret < 0; t++) begin
      tick();
      if (acc[1]) begin
        a = cyc;
        in_valid[1] = 1'b0;
      end
      if (a >= 0 && g_o[1] && rise < 0) rise = cyc;
      if (a >= 0 && g_o[1]) glen++;
      if (a >= 0 && cyc > a && in_ready[1]) rdy_ret = cyc;
    end
    check("cus_rise", 32'(rise - a), 32'd3);
    check("cus_glen", 32'(glen), 32'd2);
    check("cus_ready", 32'(rdy_ret - a), 32'd9);
    check("cus_d", 32'(d_o[1]), 32'h5);

    // Randomized traffic on both instances.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = W'($urandom);
      end
      tick();
    end
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Abort while the gate is open.
    in_valid[0] = 1'b1;
    in_data[0]  = 4'hF;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      tick();
      if (g_o[0]) seen = 1'b1;
    end
    check("abort_gate_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_g", 32'(g_o[0]), 32'd0);
    check("abort_d", 32'(d_o[0]), 32'd0);
    check("abort_lc", 32'(lc_o[0]), 32'd0);
    model_reset();
    check_all();
    tick();
    rst = 1'b0;

    // 257 loads to wrap the 8-bit load counter.
    in_valid[0] = 1'b1;
    prev_lc = 0;
    for (int t = 0; t < 1500 && m_lc[0] < 257; t++) begin
      in_data[0] = W'($urandom);
      tick();
      if (m_lc[0] != prev_lc) begin
        prev_lc = m_lc[0];
        if (m_lc[0] == 255) check("wrap_255", 32'(lc_o[0]), 32'd255);
        if (m_lc[0] == 256) check("wrap_256", 32'(lc_o[0]), 32'd0);
        if (m_lc[0] == 257) check("wrap_257", 32'(lc_o[0]), 32'd1);
      end
    end
    check("wrap_done", 32'(m_lc[0]), 32'd257);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
